serial_compare_driver: RTL and testbench
========================================

SERIAL_COMPARE_DRIVER -- requirements
Module: serial_compare_driver

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 in_valid  in  1  operand pair on a/b is valid.
REQ-005 in_ready  out  1  block accepts an operand pair this cycle.
REQ-006 a  in  WIDTH  first operand, unsigned.
REQ-007 b  in  WIDTH  second operand, unsigned.
REQ-008 ser_x  out  1  serial bit of a, MSB first, to comparator x.
REQ-009 ser_y  out  1  serial bit of b, MSB first, to comparator y.
REQ-010 cmp_clear  out  1  active-high clear to comparator reset input.
REQ-011 cmp_gt  in  1  comparator greater-than flag.
REQ-012 cmp_lt  in  1  comparator less-than flag.
REQ-013 out_valid  out  1  result on gt/lt/eq/err is valid.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 gt, lt, eq, err  out  1 each  registered comparison result.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, SHIFT, SAMPLE, RESULT.
REQ-017 IDLE: in_ready=1; on in_valid, a and b SHALL be loaded into shift registers and the FSM SHALL go to CLEAR.
REQ-018 In all states other than IDLE, in_ready SHALL be 0; no second operand pair is accepted until the result handshake completes.
REQ-019 CLEAR: one cycle; cmp_clear=1; ser_x=ser_y=0; next state SHIFT with bit counter = WIDTH-1.
REQ-020 SHIFT: exactly WIDTH cycles; ser_x/ser_y SHALL equal the current MSB of each shift register; both registers shift left by one each cycle; the counter decrements each cycle; SHIFT exits to SAMPLE when counter = 0.
REQ-021 Outside SHIFT, ser_x and ser_y SHALL be 0; outside CLEAR, cmp_clear SHALL be 0.
REQ-022 SAMPLE: one cycle; captures cmp_gt and cmp_lt; goes to RESULT.
REQ-023 Captured result: gt=cmp_gt&~cmp_lt; lt=cmp_lt&~cmp_gt; eq=~cmp_gt&~cmp_lt; err=cmp_gt&cmp_lt (gt=lt=eq=0 when err=1).
REQ-024 RESULT: out_valid=1; gt/lt/eq/err SHALL hold stable until out_valid&out_ready, then the FSM SHALL go to IDLE.
REQ-025 Latency: out_valid SHALL rise exactly WIDTH+2 clock edges after the accepting edge (in_valid&in_ready).
REQ-026 Throughput: minimum WIDTH+4 cycles per operand pair with out_ready tied high.
REQ-027 Counter width: $clog2(WIDTH) bits; no wrap beyond 0 is permitted.

Reset
REQ-028 reset low SHALL immediately force IDLE, regardless of state, and clear shift registers, counter, and result registers.
REQ-029 During reset: in_ready=0, out_valid=0, ser_x=ser_y=0, cmp_clear=1, gt=lt=eq=err=0.
REQ-030 After reset deasserts, in_ready=1 from the first clock edge; an interrupted comparison is discarded with no result.

Structure
REQ-031 Package serial_cmp_pkg SHALL hold the state enum and the default WIDTH constant.
REQ-032 Sub-module piso_shifter (parallel-load, MSB-first, shift-enable) SHALL be instantiated twice, once per operand.

Verification (WIDTH=8; bench contains the serial comparator as the downstream model)
REQ-033 a=0xA5, b=0x5A, out_ready=1 -> out_valid at edge 10 after accept; gt=1, lt=0, eq=0, err=0.
REQ-034 a=0x00, b=0xFF -> lt=1, gt=0, eq=0; ser_y=1 for all 8 SHIFT cycles, ser_x=0.
REQ-035 a=0x3C, b=0x3C -> eq=1, gt=lt=err=0.
REQ-036 Result with out_ready held low for 5 cycles -> out_valid and flags stable, in_ready=0 throughout; in_ready=1 one cycle after the handshake.
REQ-037 reset asserted during the 4th SHIFT cycle -> outputs go to reset values immediately; after release, the next pair (0x01 vs 0x02) yields lt=1.
REQ-038 Comparator model forced to cmp_gt=cmp_lt=1 -> err=1, gt=lt=eq=0.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial comparator driver.
// Holds the controller state encoding and the default operand width.
package serial_cmp_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESULT = 3'd4
  } cmp_state_e;

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shift register, MSB first.
// A load takes priority over a shift in the same cycle.
module piso_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift_en) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_compare_driver.sv
// Serialises an operand pair MSB-first into an external bit-serial comparator,
// then samples its gt/lt flags and returns a registered four-way result.
module serial_compare_driver
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ser_x,
  output logic             ser_y,
  output logic             cmp_clear,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             err,
  output cmp_state_e       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the payload is held while valid.
  cmp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             shifting;
  logic             msb_x, msb_y;

  assign accept   = in_valid & in_ready;
  assign shifting = (state_q == ST_SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_SHIFT;
      ST_SHIFT:  if (cnt_q == '0) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_RESULT;
      ST_RESULT: if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Counter parks at zero on the last shift cycle rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      cnt_q <= CNT_W'(WIDTH - 1);
    end else if (shifting && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gt  <= 1'b0;
      lt  <= 1'b0;
      eq  <= 1'b0;
      err <= 1'b0;
    end else if (state_q == ST_SAMPLE) begin
      gt  <= cmp_gt & ~cmp_lt;
      lt  <= cmp_lt & ~cmp_gt;
      eq  <= ~cmp_gt & ~cmp_lt;
      err <= cmp_gt & cmp_lt;
    end
  end

  piso_shifter #(.WIDTH(WIDTH)) u_shift_x (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift_en (shifting),
    .din      (a),
    .msb      (msb_x)
  );

  piso_shifter #(.WIDTH(WIDTH)) u_shift_y (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift_en (shifting),
    .din      (b),
    .msb      (msb_y)
  );

  // Reset level gates the handshake outputs so they read idle while reset is held.
  assign in_ready  = reset & (state_q == ST_IDLE);
  assign out_valid = reset & (state_q == ST_RESULT);
  assign cmp_clear = ~reset | (state_q == ST_CLEAR);
  assign ser_x     = shifting & msb_x;
  assign ser_y     = shifting & msb_y;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_compare_driver.sv
// Directed bench for serial_compare_driver with a bit-serial comparator model
// downstream; expected results are hand-computed and queued per transaction.
module tb_serial_compare_driver;
  import serial_cmp_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ser_x, ser_y, cmp_clear;
  logic         cmp_gt, cmp_lt;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         gt, lt, eq, err;
  cmp_state_e   dbg_state;

  logic         m_gt = 1'b0;
  logic         m_lt = 1'b0;
  logic         force_err = 1'b0;
  int           cyc = 0;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  serial_compare_driver #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ser_x     (ser_x),
    .ser_y     (ser_y),
    .cmp_clear (cmp_clear),
    .cmp_gt    (cmp_gt),
    .cmp_lt    (cmp_lt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit-serial comparator: first differing bit (MSB first) decides.
  always @(posedge clk) begin
    if (cmp_clear) begin
      m_gt <= 1'b0;
      m_lt <= 1'b0;
    end else if (!m_gt && !m_lt) begin
      if (ser_x && !ser_y) m_gt <= 1'b1;
      else if (!ser_x && ser_y) m_lt <= 1'b1;
    end
  end
  assign cmp_gt = m_gt | force_err;
  assign cmp_lt = m_lt | force_err;

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: in_ready=%b required=1", in_ready);
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL result_timeout: out_valid never rose within 30 cycles");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    total++;
    if ({in_ready, out_valid, ser_x, ser_y, cmp_clear} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_ctrl: rdy/ov/sx/sy/clr=%b required=00001",
               {in_ready, out_valid, ser_x, ser_y, cmp_clear});
    end
    total++;
    if ({gt, lt, eq, err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: flags=%b required=0000", {gt, lt, eq, err});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({in_ready, cmp_clear, dbg_state} !== {1'b1, 1'b0, ST_IDLE}) begin
      bad++;
      $display("FAIL reset_release: rdy=%b clr=%b st=%0d required rdy=1 clr=0 st=0",
               in_ready, cmp_clear, dbg_state);
    end
  endtask

  task automatic test_gt();
    int lat;
    logic [3:0] exp;
    exp_q.push_back(4'b1000);
    send(8'hA5, 8'h5A);
    wait_result(lat);
    total++;
    if (lat !== 10) begin
      bad++;
      $display("FAIL gt_latency: edges=%0d required=10", lat);
    end
    exp = exp_q.pop_front();
    total++;
    if ({gt, lt, eq, err} !== exp) begin
      bad++;
      $display("FAIL gt_flags: flags=%b required=%b", {gt, lt, eq, err}, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lt_serial();
    logic [3:0] exp;
    exp_q.push_back(4'b0100);
    send(8'h00, 8'hFF);
    total++;
    if ({cmp_clear, ser_x, ser_y} !== 3'b100) begin
      bad++;
      $display("FAIL lt_clear: clr/sx/sy=%b required=100", {cmp_clear, ser_x, ser_y});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      total++;
      if ({ser_x, ser_y, cmp_clear} !== 3'b010) begin
        bad++;
        $display("FAIL lt_shift%0d: sx/sy/clr=%b required=010", i, {ser_x, ser_y, cmp_clear});
      end
      @(posedge clk);
      #1;
    end
    total++;
    if ({ser_x, ser_y, out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL lt_sample: sx/sy/ov=%b required=000", {ser_x, ser_y, out_valid});
    end
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    total++;
    if ({out_valid, gt, lt, eq, err} !== {1'b1, exp}) begin
      bad++;
      $display("FAIL lt_flags: ov+flags=%b required=1%b", {out_valid, gt, lt, eq, err}, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_eq();
    int lat;
    logic [3:0] exp;
    exp_q.push_back(4'b0010);
    send(8'h3C, 8'h3C);
    wait_result(lat);
    exp = exp_q.pop_front();
    total++;
    if ({gt, lt, eq, err} !== exp) begin
      bad++;
      $display("FAIL eq_flags: flags=%b required=%b", {gt, lt, eq, err}, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [3:0] exp;
    out_ready = 1'b0;
    exp_q.push_back(4'b1000);
    send(8'h80, 8'h7F);
    wait_result(lat);
    exp = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, in_ready, gt, lt, eq, err} !== {2'b10, exp}) begin
        bad++;
        $display("FAIL hold%0d: ov/rdy/flags=%b required=10%b", i,
                 {out_valid, in_ready, gt, lt, eq, err}, exp);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL hold_release: rdy/ov=%b required=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    logic [3:0] exp;
    logic seen;
    send(8'hF0, 8'h0F);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (dbg_state !== ST_SHIFT) begin
      bad++;
      $display("FAIL midrst_pre: state=%0d required=%0d", dbg_state, ST_SHIFT);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, ser_x, ser_y, cmp_clear, gt, lt, eq, err} !== 9'b000010000 ||
        dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL midrst_outs: rdy/ov/sx/sy/clr/flags=%b st=%0d required=000010000 st=0",
               {in_ready, out_valid, ser_x, ser_y, cmp_clear, gt, lt, eq, err}, dbg_state);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL midrst_discard: stray activity=%b required=0", seen);
    end
    exp_q.push_back(4'b0100);
    send(8'h01, 8'h02);
    wait_result(lat);
    exp = exp_q.pop_front();
    total++;
    if ({gt, lt, eq, err} !== exp) begin
      bad++;
      $display("FAIL midrst_next: flags=%b required=%b", {gt, lt, eq, err}, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_err();
    int lat;
    logic [3:0] exp;
    force_err = 1'b1;
    exp_q.push_back(4'b0001);
    send(8'h12, 8'h34);
    wait_result(lat);
    exp = exp_q.pop_front();
    total++;
    if ({gt, lt, eq, err} !== exp) begin
      bad++;
      $display("FAIL err_flags: flags=%b required=%b", {gt, lt, eq, err}, exp);
    end
    force_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    int c0;
    logic [3:0] exp;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    send(8'h40, 8'h41);
    c0 = cyc;
    wait_result(lat);
    exp = exp_q.pop_front();
    total++;
    if ({in_ready, gt, lt, eq, err} !== {1'b0, exp}) begin
      bad++;
      $display("FAIL b2b_first: rdy+flags=%b required=0%b", {in_ready, gt, lt, eq, err}, exp);
    end
    @(posedge clk);
    #1;
    send(8'hFF, 8'hFE);
    total++;
    if (cyc - c0 !== 12) begin
      bad++;
      $display("FAIL b2b_period: cycles=%0d required=12", cyc - c0);
    end
    wait_result(lat);
    exp = exp_q.pop_front();
    total++;
    if ({gt, lt, eq, err} !== exp) begin
      bad++;
      $display("FAIL b2b_second: flags=%b required=%b", {gt, lt, eq, err}, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_gt();
    test_lt_serial();
    test_eq();
    test_backpressure();
    test_reset_mid_shift();
    test_err();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
